fp_multiplier_seq: RTL and testbench
====================================

// Module: fp_multiplier_seq
// PURPOSE
//   Iterative IEEE-754 single-precision multiplier. It is the inverse-operation partner of
//   fp_divider and sits beside it in the FPU datapath.
//   A start/busy/done handshake lets the FPU controller issue A*B and collect Out with a
//   fixed latency. Mantissas are combined by a shift-add loop. Rounding is truncation,
//   matching fp_divider.
// PARAMETERS
//   RADIX_BITS  1  multiplier bits retired per MUL cycle; legal values 1, 2, 3, 4, 6, 8
//                  (must divide 24)
// PORTS
//   int_clk  input   1   single clock; all state changes on the rising edge
//   reset_n  input   1   synchronous active-low reset
//   start    input   1   request; sampled only in IDLE
//   A        input   32  operand A (IEEE-754 single); captured on the accepting edge
//   B        input   32  operand B (IEEE-754 single); captured on the accepting edge
//   busy     output  1   high from the accepting edge until done is raised
//   done     output  1   one-cycle pulse: Out is valid and updated
//   Out      output  32  product; holds its value until the next done
// BEHAVIOUR
//   Reset (reset_n==0 at an edge): state=IDLE, busy=0, done=0, Out=32'h0, count=0.
//     Reset wins over start, and aborts an in-flight operation with no done pulse.
//   States:
//     IDLE --start--> MUL.
//       Latch the sign (A[31]^B[31]), exponents, and mantissas {1,frac}.
//       Clear the 48-bit accumulator. count=0, busy=1.
//     MUL: each edge adds (mcand << count) for each of the RADIX_BITS low multiplier bits,
//       then shifts the multiplier right by RADIX_BITS. count+=RADIX_BITS.
//       MUL -> NORM when count reaches 24.
//     NORM: one edge. Write Out, set done=1, busy=0, and return to IDLE.
//   Latency: done is high in the cycle after edge N = 24/RADIX_BITS+1 following the
//     accepting edge (N=25 by default). Latency is constant and does not depend on the data.
//   start while busy is ignored (no queueing). start in the same cycle as done (state=IDLE
//     again after the NORM edge) is accepted on the next edge: back-to-back issue is allowed.
//   done is never high for 2 consecutive cycles. busy and done are never both high.
//   Normalisation on 48-bit product P:
//     if P[47]: frac=P[46:24], e=ea+eb-126
//     else:     frac=P[45:23], e=ea+eb-127
//     Compute e in 10-bit signed; lower bits are truncated.
//   Special cases (evaluated in NORM; the loop still runs, so latency is unchanged):
//     - ea==255 or eb==255, and the other operand is zero (exp==0) -> 32'h7fc00000 (NaN)
//     - ea==255 or eb==255 otherwise -> {s,8'hff,23'h0} (inf). Fraction is ignored: no NaN
//       propagation.
//     - ea==0 or eb==0 -> {s,31'h0}. Denormals are flushed to zero.
//     - e>=255 -> {s,8'hff,23'h0}
//     - e<=0   -> {s,31'h0}
//   A and B may change after the accepting edge without affecting the result.
// TESTING
//   1. A=41000000 (8), B=40000000 (2), pulse start -> done after 25 cycles, Out=41800000 (16).
//   2. A=40200000 (2.5), B=c0b00000 (-5.5) -> Out=c15c0000 (-13.75). Repeat with both
//      operands negative -> 415c0000.
//   3. A=00000000, B=c2c80000 -> Out=80000000. A=7f800000, B=00000000 -> Out=7fc00000.
//   4. A=7f000000, B=40000000 -> Out=7f800000 (overflow).
//      A=00800000, B=3f000000 -> Out=00000000 (underflow).
//   5. Pulse start again 5 cycles into an operation with different A/B -> ignored.
//      Exactly one done, with the first result. Then issue a second op in the cycle done is
//      high -> accepted, second done 26 cycles after the first.
//   6. reset_n=0 for one edge mid-MUL -> busy=0, done=0, Out=0 next cycle, and no done
//      follows. A fresh start then yields the correct result. Rerun 1-2 with RADIX_BITS=4
//      -> latency 7.

Source files
------------

// File: rtl/fp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier, shift-add mantissa loop,
// truncating rounding, fixed latency of 24/RADIX_BITS+1 edges after start.
// Ports: int_clk, reset_n (sync, active low), start, A, B -> busy, done, Out.
module fp_multiplier_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        int_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM
    } state_t;

    localparam logic [4:0] STEP = 5'(RADIX_BITS);

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [23:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] out_q, out_d;

    logic [9:0]  exp_n;
    logic [22:0] frac_n;
    logic [31:0] res;
    logic        unused_lsbs;

    always_ff @(posedge int_clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (count_q + STEP == 5'd24) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Normalise the product; bits below the kept fraction are dropped.
    always_comb begin
        if (acc_q[47]) begin
            frac_n = acc_q[46:24];
            exp_n  = {2'b0, ea_q} + {2'b0, eb_q} - 10'd126;
        end else begin
            frac_n = acc_q[45:23];
            exp_n  = {2'b0, ea_q} + {2'b0, eb_q} - 10'd127;
        end

        if ((ea_q == 8'hff && eb_q == 8'h00) ||
            (eb_q == 8'hff && ea_q == 8'h00)) begin
            res = 32'h7fc00000;
        end else if (ea_q == 8'hff || eb_q == 8'hff) begin
            res = {sign_q, 8'hff, 23'h0};
        end else if (ea_q == 8'h00 || eb_q == 8'h00) begin
            res = {sign_q, 31'h0};
        end else if (!exp_n[9] && exp_n >= 10'd255) begin
            res = {sign_q, 8'hff, 23'h0};
        end else if (exp_n[9] || exp_n == 10'd0) begin
            res = {sign_q, 31'h0};
        end else begin
            res = {sign_q, exp_n[7:0], frac_n};
        end
    end

    assign unused_lsbs = ^acc_q[22:0];

    always_comb begin
        logic [5:0] shamt;
        shamt    = '0;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_d    = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = A[31] ^ B[31];
                    ea_d     = A[30:23];
                    eb_d     = B[30:23];
                    mcand_d  = {1'b1, A[22:0]};
                    mplier_d = {1'b1, B[22:0]};
                    acc_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            MUL: begin
                // Retire RADIX_BITS multiplier bits, each weighted by its position.
                for (int j = 0; j < RADIX_BITS; j++) begin
                    shamt = 6'(count_q) + 6'(j);
                    if (mplier_q[j]) acc_d = acc_d + (48'(mcand_q) << shamt);
                end
                mplier_d = mplier_q >> RADIX_BITS;
                count_d  = count_q + STEP;
            end
            NORM: begin
                out_d  = res;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Out  = out_q;
endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Randomised self-checking bench for fp_multiplier_seq, radix 1 and 4.
// Cycle model tracks busy/done/Out; directed cases pin literal results.
module tb_fp_multiplier_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start1, start4;
    logic [31:0] a_in, b_in;
    logic        busy1, done1, busy4, done4;
    logic [31:0] out1, out4;
    int          checks = 0;
    int          failures = 0;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    fp_multiplier_seq #(.RADIX_BITS(1)) dut1 (
        .int_clk(clk), .reset_n(reset_n), .start(start1),
        .A(a_in), .B(b_in), .busy(busy1), .done(done1), .Out(out1)
    );

    fp_multiplier_seq #(.RADIX_BITS(4)) dut4 (
        .int_clk(clk), .reset_n(reset_n), .start(start4),
        .A(a_in), .B(b_in), .busy(busy4), .done(done4), .Out(out4)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] f;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7fc00000;
        if (ea == 255 || eb == 255) return {s, 8'hff, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        if (p[47]) begin
            f = p[46:24];
            e = ea + eb - 126;
        end else begin
            f = p[45:23];
            e = ea + eb - 127;
        end
        if (e >= 255) return {s, 8'hff, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int mode;
        mode = int'($urandom_range(0, 9));
        if (mode == 0) e = 8'h00;
        else if (mode == 1) e = 8'hff;
        else if (mode < 6) e = 8'($urandom_range(64, 190));
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Latency-based model: an accepted op completes lat[k] edges later.
    bit          m_busy [2];
    bit          m_done [2];
    logic [31:0] m_out  [2];
    logic [31:0] m_res  [2];
    int          m_rem  [2];
    int          lat    [2] = '{25, 7};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit st;
            st = (k == 0) ? start1 : start4;
            if (!reset_n) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_out[k]  = '0;
                m_rem[k]  = 0;
            end else begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (st) begin
                        m_busy[k] = 1'b1;
                        m_res[k]  = ref_mul(a_in, b_in);
                        m_rem[k]  = lat[k];
                    end
                end else begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_out[k]  = m_res[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkint("busy1", int'(busy1), int'(m_busy[0]));
            checkint("done1", int'(done1), int'(m_done[0]));
            check32("out1", out1, m_out[0]);
            checkint("busy4", int'(busy4), int'(m_busy[1]));
            checkint("done4", int'(done4), int'(m_done[1]));
            check32("out4", out4, m_out[1]);
        end
    end

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
        a_in = a;
        b_in = b;
        if (k == 0) start1 = 1'b1;
        else start4 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
    endtask

    task automatic wait_done(input int k, input int max, output int cyc, output logic [31:0] res);
        cyc = 0;
        res = '0;
        while (cyc <= max) begin
            @(negedge clk);
            if ((k == 0) ? done1 : done4) begin
                res = (k == 0) ? out1 : out4;
                return;
            end
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int cyc;
        logic [31:0] r;
        issue(k, a, b);
        wait_done(k, 40, cyc, r);
        checkint({name, "_lat"}, cyc, lat[k]);
        check32(name, r, exp);
    endtask

    initial begin
        int cyc, ndone;
        logic [31:0] r;
        time t1, t2;
        reset_n = 1'b0;
        start1  = 1'b0;
        start4  = 1'b0;
        a_in    = '0;
        b_in    = '0;

        check32("ref_8x2", ref_mul(32'h41000000, 32'h40000000), 32'h41800000);
        check32("ref_neg", ref_mul(32'h40200000, 32'hc0b00000), 32'hc15c0000);
        check32("ref_ovf", ref_mul(32'h7f000000, 32'h40000000), 32'h7f800000);
        check32("ref_unf", ref_mul(32'h00800000, 32'h3f000000), 32'h00000000);

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);
        check32("rst_out", out1, 32'h0);
        checkint("rst_busy", int'(busy1), 0);

        run_op(0, 32'h41000000, 32'h40000000, 32'h41800000, "t1_8x2");
        run_op(0, 32'h40200000, 32'hc0b00000, 32'hc15c0000, "t2_neg");
        run_op(0, 32'hc0200000, 32'hc0b00000, 32'h415c0000, "t2_negneg");
        run_op(0, 32'h00000000, 32'hc2c80000, 32'h80000000, "t3_zero");
        run_op(0, 32'h7f800000, 32'h00000000, 32'h7fc00000, "t3_nan");
        run_op(0, 32'h7f000000, 32'h40000000, 32'h7f800000, "t4_ovf");
        run_op(0, 32'h00800000, 32'h3f000000, 32'h00000000, "t4_unf");
        run_op(0, 32'h7f800000, 32'h7f800000, 32'h7f800000, "t3_infinf");

        issue(0, 32'h41000000, 32'h40000000);
        repeat (4) @(posedge clk);
        #1;
        a_in = 32'h40200000;
        b_in = 32'hc0b00000;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(0, 40, cyc, r);
        check32("t5_ignored", r, 32'h41800000);
        t1 = $time;
        a_in = 32'h40200000;
        b_in = 32'hc0b00000;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(0, 40, cyc, r);
        t2 = $time;
        check32("t5_b2b", r, 32'hc15c0000);
        checkint("t5_gap", int'((t2 - t1) / 10), 26);

        issue(0, 32'h40200000, 32'hc0b00000);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkint("t6_busy", int'(busy1), 0);
        checkint("t6_done", int'(done1), 0);
        check32("t6_out", out1, 32'h0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        checkint("t6_nodone", ndone, 0);
        run_op(0, 32'h41000000, 32'h40000000, 32'h41800000, "t6_fresh");

        run_op(1, 32'h41000000, 32'h40000000, 32'h41800000, "r4_8x2");
        run_op(1, 32'h40200000, 32'hc0b00000, 32'hc15c0000, "r4_neg");
        run_op(1, 32'hc0200000, 32'hc0b00000, 32'h415c0000, "r4_negneg");

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a, b;
                a = rand_fp();
                b = rand_fp();
                run_op(k, a, b, ref_mul(a, b), "rand");
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
